move_scanner: RTL and testbench

Parametrised successor to the single-direction validator. Given a candidate square and a player, it walks all eight directions across the game-board RAM, reports per-direction and overall move legality plus the total capture count, and optionally writes the resulting flips back. It sits between the game-control FSM and the `gameboardRAM` port, time-shared with the initializer.

---
 rtl/othello_pkg.sv | 33 +++
 rtl/move_scanner_if.sv | 13 +
 rtl/move_scanner_board_step.sv | 33 +++
 rtl/move_scanner.sv | 273 +++++++++++++++++++++++++++
 tb/tb_move_scanner.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell codes, the eight direction deltas and the
// scanner state encoding.
package othello_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P0    = 2'b01;
    localparam logic [1:0] CELL_P1    = 2'b10;

    // d0..d7 = N, NE, E, SE, S, SW, W, NW
    localparam int DIR_DR [8] = '{-1, -1,  0,  1,  1,  1,  0, -1};
    localparam int DIR_DC [8] = '{ 0,  1,  1,  1,  0, -1, -1, -1};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ORIG_RD,
        ST_ORIG_EV,
        ST_DIR_INIT,
        ST_CELL_RD,
        ST_CELL_EV,
        ST_NEXT_DIR,
        ST_FLIP,
        ST_DONE
    } scan_state_e;

    function automatic logic [1:0] own_code(input logic player);
        return player ? CELL_P1 : CELL_P0;
    endfunction

    function automatic logic [1:0] opp_code(input logic player);
        return player ? CELL_P0 : CELL_P1;
    endfunction

endpackage

// File: rtl/move_scanner_if.sv
// Game-board RAM port shared between the scanner (master) and the RAM (slave).
// mem_q is valid in the cycle after mem_addr is presented.
interface move_scanner_if #(
    parameter int AW = 6
);
    logic [AW-1:0] mem_addr;
    logic          mem_wren;
    logic [1:0]    mem_data;
    logic [1:0]    mem_q;

    modport master (output mem_addr, output mem_wren, output mem_data, input mem_q);
    modport slave  (input mem_addr, input mem_wren, input mem_data, output mem_q);
endinterface

// File: rtl/move_scanner_board_step.sv
// board_step: one step from (row, col) in direction d. Row and column are
// bounds-checked independently so a walk can never wrap across a row edge.
module board_step
    import othello_pkg::*;
#(
    parameter  int BOARD_N = 8,
    localparam int CW      = $clog2(BOARD_N),
    localparam int AW      = $clog2(BOARD_N * BOARD_N)
) (
    input  logic [CW-1:0] row_i,
    input  logic [CW-1:0] col_i,
    input  logic [2:0]    dir_i,
    output logic [CW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          in_bounds_o,
    output logic [AW-1:0] addr_o
);
    localparam int SW = CW + 2;

    logic signed [SW-1:0] row_s;
    logic signed [SW-1:0] col_s;

    // Signed step so that leaving the top/left edge shows up as a negative coordinate.
    always_comb begin
        row_s       = $signed({2'b00, row_i}) + SW'(DIR_DR[dir_i]);
        col_s       = $signed({2'b00, col_i}) + SW'(DIR_DC[dir_i]);
        in_bounds_o = !row_s[SW-1] && (row_s < SW'(BOARD_N)) &&
                      !col_s[SW-1] && (col_s < SW'(BOARD_N));
        row_o       = row_s[CW-1:0];
        col_o       = col_s[CW-1:0];
        addr_o      = AW'(row_o) * AW'(BOARD_N) + AW'(col_o);
    end
endmodule

// File: rtl/move_scanner.sv
// move_scanner: walks all eight directions from a candidate square, reports
// per-direction and overall legality plus the capture count.
// Build option MOVE_SCANNER_FLIP_EN: adds the FLIP state that writes the
// origin and every captured cell back to the board RAM before done.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_IDLE     | waiting for start
//   ST_ORIG_RD  | origin address on the RAM port
//   ST_ORIG_EV  | origin cell evaluated, occupied -> ST_DONE
//   ST_DIR_INIT | clear run length, first step in direction d
//   ST_CELL_RD  | probed cell address on the RAM port
//   ST_CELL_EV  | probed cell evaluated: continue, capture or fail
//   ST_NEXT_DIR | advance d, or leave after d7
//   ST_FLIP     | one RAM write per cycle: origin, then captures in d order
//   ST_DONE     | done pulse, results held
module move_scanner
    import othello_pkg::*;
#(
    parameter  int BOARD_N = 8,
    localparam int CW      = $clog2(BOARD_N),
    localparam int AW      = $clog2(BOARD_N * BOARD_N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] row_in,
    input  logic [CW-1:0] col_in,
    input  logic          player,
    output logic          busy,
    output logic          done,
    output logic          valid,
    output logic [7:0]    dir_mask,
    output logic [AW-1:0] flip_count,
    move_scanner_if.master mem
);
    scan_state_e   state_q;
    logic [CW-1:0] orig_row_q, orig_col_q;
    logic [CW-1:0] cur_row_q, cur_col_q;
    logic          player_q;
    logic [2:0]    dir_q;
    logic [CW-1:0] run_q;
    logic [7:0]    mask_q;
    logic [AW-1:0] count_q;
    logic          busy_q, done_q;
    logic [AW-1:0] addr_q;

    logic [CW-1:0] step_row_d, step_col_d;
    logic [2:0]    step_dir_d;
    logic [CW-1:0] step_row, step_col;
    logic          step_ok;
    logic [AW-1:0] step_addr;

`ifdef MOVE_SCANNER_FLIP_EN
    logic [CW-1:0] len_q [8];
    logic          wren_q;
    logic [1:0]    data_q;
    logic [2:0]    fl_dir_q;
    logic [3:0]    fl_from_q;
    logic [CW-1:0] fl_rem_q;
    logic [2:0]    nd_d;
    logic          nd_found_d;
`endif

    function automatic logic [AW-1:0] cell_addr(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return AW'(r) * AW'(BOARD_N) + AW'(c);
    endfunction

    board_step #(.BOARD_N(BOARD_N)) u_step (
        .row_i       (step_row_d),
        .col_i       (step_col_d),
        .dir_i       (step_dir_d),
        .row_o       (step_row),
        .col_o       (step_col),
        .in_bounds_o (step_ok),
        .addr_o      (step_addr)
    );

`ifdef MOVE_SCANNER_FLIP_EN
    // Lowest captured direction not yet written back.
    always_comb begin
        nd_found_d = 1'b0;
        nd_d       = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (4'(i) >= fl_from_q)) begin
                nd_found_d = 1'b1;
                nd_d       = 3'(i);
            end
        end
    end
`endif

    // Step source: origin when a direction starts, otherwise the last cell visited.
    always_comb begin
        step_row_d = cur_row_q;
        step_col_d = cur_col_q;
        step_dir_d = dir_q;
        case (state_q)
            ST_DIR_INIT: begin
                step_row_d = orig_row_q;
                step_col_d = orig_col_q;
            end
`ifdef MOVE_SCANNER_FLIP_EN
            ST_FLIP: begin
                step_dir_d = fl_dir_q;
                if (fl_rem_q == '0) begin
                    step_row_d = orig_row_q;
                    step_col_d = orig_col_q;
                    step_dir_d = nd_d;
                end
            end
`endif
            default: ;
        endcase
    end

    // Scanner FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            orig_row_q <= '0;
            orig_col_q <= '0;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            player_q   <= 1'b0;
            dir_q      <= '0;
            run_q      <= '0;
            mask_q     <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
`ifdef MOVE_SCANNER_FLIP_EN
            for (int i = 0; i < 8; i++) len_q[i] <= '0;
            wren_q     <= 1'b0;
            data_q     <= 2'b00;
            fl_dir_q   <= '0;
            fl_from_q  <= '0;
            fl_rem_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        orig_row_q <= row_in;
                        orig_col_q <= col_in;
                        player_q   <= player;
                        mask_q     <= '0;
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                        addr_q     <= cell_addr(row_in, col_in);
                        state_q    <= ST_ORIG_RD;
                    end
                end
                ST_ORIG_RD: state_q <= ST_ORIG_EV;
                ST_ORIG_EV: begin
                    if (mem.mem_q == CELL_P0 || mem.mem_q == CELL_P1) begin
                        mask_q  <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        dir_q   <= '0;
                        state_q <= ST_DIR_INIT;
                    end
                end
                ST_DIR_INIT: begin
                    run_q <= '0;
                    if (step_ok) begin
                        cur_row_q <= step_row;
                        cur_col_q <= step_col;
                        addr_q    <= step_addr;
                        state_q   <= ST_CELL_RD;
                    end else begin
                        state_q   <= ST_NEXT_DIR;
                    end
                end
                ST_CELL_RD: state_q <= ST_CELL_EV;
                ST_CELL_EV: begin
                    if (mem.mem_q == opp_code(player_q)) begin
                        run_q <= run_q + 1'b1;
                        if (step_ok) begin
                            cur_row_q <= step_row;
                            cur_col_q <= step_col;
                            addr_q    <= step_addr;
                            state_q   <= ST_CELL_RD;
                        end else begin
                            state_q   <= ST_NEXT_DIR;
                        end
                    end else begin
                        if (mem.mem_q == own_code(player_q) && run_q != '0) begin
                            mask_q[dir_q] <= 1'b1;
                            count_q       <= count_q + AW'(run_q);
`ifdef MOVE_SCANNER_FLIP_EN
                            len_q[dir_q]  <= run_q;
`endif
                        end
                        state_q <= ST_NEXT_DIR;
                    end
                end
                ST_NEXT_DIR: begin
                    if (dir_q == 3'd7) begin
`ifdef MOVE_SCANNER_FLIP_EN
                        if (|mask_q) begin
                            addr_q    <= cell_addr(orig_row_q, orig_col_q);
                            wren_q    <= 1'b1;
                            data_q    <= own_code(player_q);
                            fl_dir_q  <= '0;
                            fl_from_q <= '0;
                            fl_rem_q  <= '0;
                            state_q   <= ST_FLIP;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
`else
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
`endif
                    end else begin
                        dir_q   <= dir_q + 1'b1;
                        state_q <= ST_DIR_INIT;
                    end
                end
`ifdef MOVE_SCANNER_FLIP_EN
                ST_FLIP: begin
                    if (fl_rem_q != '0) begin
                        cur_row_q <= step_row;
                        cur_col_q <= step_col;
                        addr_q    <= step_addr;
                        fl_rem_q  <= fl_rem_q - 1'b1;
                    end else if (nd_found_d) begin
                        cur_row_q <= step_row;
                        cur_col_q <= step_col;
                        addr_q    <= step_addr;
                        fl_dir_q  <= nd_d;
                        fl_from_q <= 4'(nd_d) + 4'd1;
                        fl_rem_q  <= len_q[nd_d] - 1'b1;
                    end else begin
                        wren_q  <= 1'b0;
                        data_q  <= 2'b00;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign dir_mask   = mask_q;
    assign valid      = |mask_q;
    assign flip_count = count_q;
    assign mem.mem_addr = addr_q;
`ifdef MOVE_SCANNER_FLIP_EN
    assign mem.mem_wren = wren_q;
    assign mem.mem_data = data_q;
`else
    assign mem.mem_wren = 1'b0;
    assign mem.mem_data = 2'b00;
`endif
endmodule

// File: tb/tb_move_scanner.sv
// Directed bench for move_scanner on an 8x8 board with a behavioural
// one-cycle-latency board RAM. Expectations follow MOVE_SCANNER_FLIP_EN.
module tb_move_scanner;
    import othello_pkg::*;

    localparam int N  = 8;
    localparam int CW = 3;
    localparam int AW = 6;
`ifdef MOVE_SCANNER_FLIP_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] row_in, col_in;
    logic          player;
    logic          busy, done, valid;
    logic [7:0]    dir_mask;
    logic [AW-1:0] flip_count;

    move_scanner_if #(.AW(AW)) ram_if ();

    move_scanner #(.BOARD_N(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .row_in     (row_in),
        .col_in     (col_in),
        .player     (player),
        .busy       (busy),
        .done       (done),
        .valid      (valid),
        .dir_mask   (dir_mask),
        .flip_count (flip_count),
        .mem        (ram_if)
    );

    always #5 clock = ~clock;

    logic [1:0] ram [N*N];
    int         cyc = 0;
    int         wr_addr [$];
    logic [1:0] wr_data [$];
    int         wr_cyc  [$];

    // Board RAM: registered read, write logged with the cycle it happened in.
    always @(posedge clock) begin
        cyc = cyc + 1;
        ram_if.mem_q <= ram[ram_if.mem_addr];
        if (ram_if.mem_wren) begin
            ram[ram_if.mem_addr] = ram_if.mem_data;
            wr_addr.push_back(int'(ram_if.mem_addr));
            wr_data.push_back(ram_if.mem_data);
            wr_cyc.push_back(cyc);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < N*N; i++) ram[i] = CELL_EMPTY;
    endtask

    task automatic set_cell(input int r, input int c, input logic [1:0] v);
        ram[r*N + c] = v;
    endtask

    task automatic load_standard();
        clear_board();
        set_cell(3, 3, CELL_P1);
        set_cell(4, 4, CELL_P1);
        set_cell(3, 4, CELL_P0);
        set_cell(4, 3, CELL_P0);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    // Starts a scan and returns the cycle index (1 = first cycle after accept)
    // in which done is first seen. inj != 0 pulses a stray start at that cycle.
    task automatic run_scan(input string tag, input int r, input int c, input logic p, input int inj,
                            output int ncyc, output logic busy1, output logic [7:0] mask1,
                            output logic busy_dn);
        clear_log();
        repeat (2) @(negedge clock);
        row_in = CW'(r);
        col_in = CW'(c);
        player = p;
        start  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        ncyc  = 1;
        busy1 = busy;
        mask1 = dir_mask;
        while (!done && ncyc < 200) begin
            if (ncyc == inj) begin
                start  = 1'b1;
                row_in = 3'd7;
                col_in = 3'd7;
                player = ~p;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            ncyc++;
        end
        start   = 1'b0;
        busy_dn = busy;
        check_eq({tag, " done_seen"}, done, 1'b1);
    endtask

    task automatic check_writes(input string tag, input int n_exp, input int a0, input int a1,
                                input int a2, input int a3, input logic [1:0] d);
        int ea [4];
        ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
        check_eq({tag, " n_writes"}, wr_addr.size(), n_exp);
        for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
            check_eq($sformatf("%s wr_addr%0d", tag, i), wr_addr[i], ea[i]);
            check_eq($sformatf("%s wr_data%0d", tag, i), wr_data[i], d);
            if (i > 0) check_eq($sformatf("%s wr_gap%0d", tag, i), wr_cyc[i] - wr_cyc[i-1], 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic       b1, bd;
        logic [7:0] m1;

        reset  = 1'b1;
        start  = 1'b0;
        row_in = '0;
        col_in = '0;
        player = 1'b0;
        clear_board();
        repeat (3) @(posedge clock); #1;
        reset = 1'b0;
        check_eq("rst busy",  busy, 1'b0);
        check_eq("rst done",  done, 1'b0);
        check_eq("rst valid", valid, 1'b0);
        check_eq("rst mask",  dir_mask, 8'h00);
        check_eq("rst count", flip_count, 0);
        check_eq("rst wren",  ram_if.mem_wren, 1'b0);
        check_eq("rst data",  ram_if.mem_data, 2'b00);

        // Opening move P0 at (2,3): captures (3,3) southwards.
        // Scan: 2 + 7 dirs x 4 + S (1+2x2+1) = 36, done in 37; flip adds 2.
        load_standard();
        run_scan("open", 2, 3, 1'b0, 0, n, b1, m1, bd);
        check_eq("open busy1",  b1, 1'b1);
        check_eq("open busy_dn", bd, 1'b0);
        check_eq("open ncyc",   n, FLIP ? 39 : 37);
        check_eq("open valid",  valid, 1'b1);
        check_eq("open mask",   dir_mask, 8'h10);
        check_eq("open count",  flip_count, 1);
        check_writes("open", FLIP ? 2 : 0, 19, 27, 0, 0, CELL_P0);
        check_eq("open ram33",  ram[27], FLIP ? CELL_P0 : CELL_P1);
        repeat (3) @(posedge clock); #1;
        check_eq("open done_pulse", done, 1'b0);
        check_eq("open mask_hold",  dir_mask, 8'h10);

        // Occupied origin: done in cycle 3, results cleared by the start.
        load_standard();
        run_scan("occ", 3, 3, 1'b0, 0, n, b1, m1, bd);
        check_eq("occ mask1", m1, 8'h00);
        check_eq("occ ncyc",  n, 3);
        check_eq("occ valid", valid, 1'b0);
        check_eq("occ mask",  dir_mask, 8'h00);
        check_writes("occ", 0, 0, 0, 0, 0, CELL_P0);

        // Corner (0,0) P1: 5 dirs out of bounds (2 each), E/SE/S one empty cell (4 each).
        // 2 + 10 + 12 = 24, done in 25. A stray start mid-scan is ignored.
        load_standard();
        run_scan("corner", 0, 0, 1'b1, 5, n, b1, m1, bd);
        check_eq("corner ncyc",  n, 25);
        check_eq("corner mask",  dir_mask, 8'h00);
        check_eq("corner count", flip_count, 0);
        check_writes("corner", 0, 0, 0, 0, 0, CELL_P1);

        // Wrap guard: E run of opponents hits col 8; (3,0) must not close it.
        clear_board();
        set_cell(2, 5, CELL_P1);
        set_cell(2, 6, CELL_P1);
        set_cell(2, 7, CELL_P1);
        set_cell(3, 0, CELL_P0);
        run_scan("wrap", 2, 4, 1'b0, 0, n, b1, m1, bd);
        check_eq("wrap ncyc",  n, 39);
        check_eq("wrap valid", valid, 1'b0);
        check_eq("wrap mask",  dir_mask, 8'h00);
        check_writes("wrap", 0, 0, 0, 0, 0, CELL_P0);

        // Two directions: N captures (3,4),(2,4); W captures (4,3).
        // Scan 2 + 8 + 6 + 24 = 40; flip writes 36, 28, 20, 35.
        clear_board();
        set_cell(3, 4, CELL_P1);
        set_cell(2, 4, CELL_P1);
        set_cell(1, 4, CELL_P0);
        set_cell(4, 3, CELL_P1);
        set_cell(4, 2, CELL_P0);
        run_scan("multi", 4, 4, 1'b0, 0, n, b1, m1, bd);
        check_eq("multi ncyc",  n, FLIP ? 45 : 41);
        check_eq("multi mask",  dir_mask, 8'h41);
        check_eq("multi count", flip_count, 3);
        check_writes("multi", FLIP ? 4 : 0, 36, 28, 20, 35, CELL_P0);

        // Reset in cycle 17 of the opening scan = CELL_EV of d3.
        load_standard();
        clear_log();
        repeat (2) @(negedge clock);
        row_in = 3'd2;
        col_in = 3'd3;
        player = 1'b0;
        start  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (16) @(posedge clock); #1;
        check_eq("rmid busy_before", busy, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_eq("rmid busy",  busy, 1'b0);
        check_eq("rmid done",  done, 1'b0);
        check_eq("rmid valid", valid, 1'b0);
        check_eq("rmid mask",  dir_mask, 8'h00);
        check_eq("rmid count", flip_count, 0);
        check_eq("rmid wren",  ram_if.mem_wren, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("rmid wren2", ram_if.mem_wren, 1'b0);
        check_eq("rmid ram23", ram[19], CELL_EMPTY);
        check_eq("rmid ram33", ram[27], CELL_P1);
        check_eq("rmid nwr",   wr_addr.size(), 0);
        run_scan("after", 2, 3, 1'b0, 0, n, b1, m1, bd);
        check_eq("after ncyc",  n, FLIP ? 39 : 37);
        check_eq("after mask",  dir_mask, 8'h10);
        check_eq("after count", flip_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
